// File: rtl/fetch_txn_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_pkg
// Purpose  : Shared types and round-robin pick for the fetch txn sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_seq_pkg;

   localparam int MAX_CH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_ERR     = 2'b01,
      ST_TIMEOUT = 2'b10
   } status_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // First requester at or after ptr, wrapping modulo n (ptr < n assumed).
   function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                        input logic [2:0]        ptr,
                                        input logic [3:0]        n);
      rr_pick_t   r;
      logic [3:0] c;
      r = '0;
      for (int k = 0; k < MAX_CH; k++) begin
         c = {1'b0, ptr} + 4'(k);
         if (c >= n) c = c - n;
         if (!r.found && (4'(k) < n) && req[c[2:0]]) begin
            r.found = 1'b1;
            r.idx   = c[2:0];
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_rr_arbiter
// Purpose  : Round-robin one-hot grant from a request vector and a pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int AW     = 1
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [AW-1:0]     i_ptr,
   input  logic              i_en,
   output logic [NUM_CH-1:0] o_grant,
   output logic [AW-1:0]     o_idx,
   output logic              o_any
);
   import fetch_seq_pkg::*;

   logic [MAX_CH-1:0] w_req_ext;
   rr_pick_t          w_pick;

   assign w_req_ext = MAX_CH'(i_req);
   assign w_pick    = rr_pick(w_req_ext, 3'(i_ptr), 4'(NUM_CH));

   assign o_any   = i_en & w_pick.found;
   assign o_idx   = AW'(w_pick.idx);
   assign o_grant = o_any ? (NUM_CH'(1) << w_pick.idx) : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_txn_sequencer
// Purpose  : Round-robin sequencing of AXI master init/done/error handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_txn_sequencer #(
   parameter int NUM_CH            = 2,
   parameter int INIT_PULSE_CYCLES = 2,
   parameter int TIMEOUT_CYCLES    = 4096,
   parameter int CNT_W             = 16,
   localparam int AW               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                enable,
   input  logic [NUM_CH-1:0]   req_valid,
   output logic [NUM_CH-1:0]   req_ready,
   output logic [NUM_CH-1:0]   init_axi_txn,
   input  logic [NUM_CH-1:0]   txn_done,
   input  logic [NUM_CH-1:0]   txn_error,
   output logic [NUM_CH-1:0]   rsp_valid,
   output logic [2*NUM_CH-1:0] rsp_status,
   output logic                busy,
   output logic [AW-1:0]       active_ch,
   output logic [CNT_W-1:0]    ok_cnt,
   output logic [CNT_W-1:0]    err_cnt
);
   import fetch_seq_pkg::*;

   localparam int PW = (INIT_PULSE_CYCLES > 1) ? $clog2(INIT_PULSE_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [AW-1:0]       r_ptr;
   logic [AW-1:0]       r_active;
   logic [PW-1:0]       r_pcnt;
   logic [TW-1:0]       r_timer;
   logic [NUM_CH-1:0]   r_done_q;
   logic [2*NUM_CH-1:0] r_status;
   logic [CNT_W-1:0]    r_ok;
   logic [CNT_W-1:0]    r_err;

   logic [NUM_CH-1:0]   w_grant;
   logic [AW-1:0]       w_win_idx;
   logic                w_any;
   logic                w_arb_en;
   logic [NUM_CH-1:0]   w_edge;
   logic                w_cmpl;
   logic                w_tmo;
   logic                w_finish;
   logic [NUM_CH-1:0]   w_active_oh;
   logic [NUM_CH-1:0]   w_init;
   logic [NUM_CH-1:0]   w_rsp;
   status_t             w_new_status;

   assign w_arb_en = enable & ~ARESET & (r_state == S_IDLE);

   fetch_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .AW     (AW)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .i_en    (w_arb_en),
      .o_grant (w_grant),
      .o_idx   (w_win_idx),
      .o_any   (w_any)
   );

   // Only a rising edge counts, so a TXN_DONE left high from the last
   // transaction cannot complete the next one.
   assign w_edge       = txn_done & ~r_done_q;
   assign w_cmpl       = w_edge[r_active];
   assign w_tmo        = (r_timer == TW'(TIMEOUT_CYCLES - 1));
   assign w_finish     = (r_state == S_WAIT) && (w_cmpl || w_tmo);
   assign w_active_oh  = NUM_CH'(1) << r_active;
   assign w_new_status = w_cmpl ? (txn_error[r_active] ? ST_ERR : ST_OK) : ST_TIMEOUT;

   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_init      = '0;
      w_rsp       = '0;
      case (r_state)
         S_IDLE: if (w_any) w_state_nxt = S_INIT;
         S_INIT: begin
            w_init = w_active_oh;
            if (r_pcnt == PW'(INIT_PULSE_CYCLES - 1)) w_state_nxt = S_WAIT;
         end
         S_WAIT: if (w_cmpl || w_tmo) w_state_nxt = S_RESP;
         S_RESP: begin
            w_rsp       = w_active_oh;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_ptr    <= '0;
         r_active <= '0;
         r_pcnt   <= '0;
         r_timer  <= '0;
         r_done_q <= '0;
         r_status <= '0;
         r_ok     <= '0;
         r_err    <= '0;
      end else begin
         r_done_q <= txn_done;
         if (w_any) begin
            r_active <= w_win_idx;
            r_ptr    <= (w_win_idx == AW'(NUM_CH - 1)) ? '0 : w_win_idx + 1'b1;
         end
         r_pcnt  <= (r_state == S_INIT) ? r_pcnt + 1'b1 : '0;
         r_timer <= (r_state == S_WAIT) ? r_timer + 1'b1 : '0;
         // Status and counters are updated entering RESP so they are
         // already visible alongside rsp_valid.
         if (w_finish) begin
            r_status[2*r_active +: 2] <= w_new_status;
            if (w_new_status == ST_OK) begin
               if (r_ok != '1) r_ok <= r_ok + 1'b1;
            end else begin
               if (r_err != '1) r_err <= r_err + 1'b1;
            end
         end
      end
   end

   assign req_ready    = w_grant;
   assign init_axi_txn = w_init;
   assign rsp_valid    = w_rsp;
   assign rsp_status   = r_status;
   assign busy         = (r_state != S_IDLE);
   assign active_ch    = r_active;
   assign ok_cnt       = r_ok;
   assign err_cnt      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_txn_sequencer
// Purpose  : Directed plus randomized checks against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_txn_sequencer;

   localparam int NCH = 2;
   localparam int P   = 2;
   localparam int T   = 16;

   logic           clk;
   logic           ARESET;
   logic           enable;
   logic [NCH-1:0] req_valid, req_ready, init_axi_txn, txn_done, txn_error, rsp_valid;
   logic [2*NCH-1:0] rsp_status;
   logic           busy;
   logic           active_ch;
   logic [15:0]    ok_cnt, err_cnt;

   fetch_txn_sequencer #(
      .NUM_CH(NCH), .INIT_PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .CNT_W(16)
   ) dut (
      .ACLK(clk), .ARESET(ARESET), .enable(enable), .req_valid(req_valid),
      .req_ready(req_ready), .init_axi_txn(init_axi_txn), .txn_done(txn_done),
      .txn_error(txn_error), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
      .busy(busy), .active_ch(active_ch), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Transaction-level reference: a grant at cycle g fixes the init window
   // and the wait window; completion/timeout fixes the response cycle.
   bit             m_valid = 0, m_idle = 1, m_busy, m_found;
   int             m_ptr, m_ch, m_g, m_resp, m_wst, cyc = 0;
   logic [1:0]     m_st;
   logic [1:0]     m_stat [NCH];
   int             m_ok, m_err;
   logic [NCH-1:0] m_dq, m_edge, e_ready, e_init, e_rsp;

   always @(negedge clk) begin
      if (ARESET) begin
         m_valid = 1; m_idle = 1; m_ptr = 0; m_ok = 0; m_err = 0; m_dq = '0;
         for (int c = 0; c < NCH; c++) m_stat[c] = 2'b00;
      end else if (m_valid) begin
         m_edge  = txn_done & ~m_dq;
         e_ready = '0; e_init = '0; e_rsp = '0;
         m_busy  = !m_idle;
         if (m_idle) begin
            if (enable && req_valid != '0) begin
               m_found = 0;
               for (int k = 0; k < NCH; k++) begin
                  if (!m_found && req_valid[(m_ptr + k) % NCH]) begin
                     m_found = 1; m_ch = (m_ptr + k) % NCH;
                  end
               end
               e_ready[m_ch] = 1'b1;
               m_idle = 0; m_g = cyc; m_resp = -1; m_ptr = (m_ch + 1) % NCH;
            end
         end else begin
            m_wst = m_g + P + 1;
            if (cyc - m_g >= 1 && cyc - m_g <= P) e_init[m_ch] = 1'b1;
            if (cyc == m_resp) begin
               e_rsp[m_ch] = 1'b1;
               m_stat[m_ch] = m_st;
               if (m_st == 2'b00) m_ok = (m_ok < 65535) ? m_ok + 1 : m_ok;
               else               m_err = (m_err < 65535) ? m_err + 1 : m_err;
            end else if (m_resp < 0 && cyc >= m_wst) begin
               if (m_edge[m_ch]) begin
                  m_resp = cyc + 1; m_st = txn_error[m_ch] ? 2'b01 : 2'b00;
               end else if (cyc - m_wst == T - 1) begin
                  m_resp = cyc + 1; m_st = 2'b10;
               end
            end
         end
         check_val("ready", 32'(req_ready), 32'(e_ready));
         check_val("init", 32'(init_axi_txn), 32'(e_init));
         check_val("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
         check_val("busy", 32'(busy), 32'(m_busy));
         if (m_busy) check_val("active_ch", 32'(active_ch), 32'(m_ch));
         check_val("rsp_status", 32'(rsp_status), 32'({m_stat[1], m_stat[0]}));
         check_val("ok_cnt", 32'(ok_cnt), 32'(m_ok));
         check_val("err_cnt", 32'(err_cnt), 32'(m_err));
         if (m_busy && cyc == m_resp) m_idle = 1;
         m_dq = txn_done;
      end
      cyc++;
   end

   // Auto responder: after an init pulse falls, raise done after a random
   // delay; stale-high done sometimes kept to force timeouts.
   bit auto_en = 0;
   int ar_cnt  [NCH];
   bit ar_prev [NCH];

   task automatic tick();
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (auto_en) begin
            if (ar_prev[c] && !init_axi_txn[c]) begin
               ar_cnt[c] = $urandom_range(1, 20);
               if ($urandom_range(0, 1) == 0) txn_done[c] = 1'b0;
            end else if (ar_cnt[c] > 0) begin
               ar_cnt[c]--;
               if (ar_cnt[c] == 0) begin
                  txn_done[c]  = 1'b1;
                  txn_error[c] = 1'($urandom_range(0, 1));
               end
            end else if (txn_done[c] && $urandom_range(0, 3) == 0) begin
               txn_done[c] = 1'b0;
            end
         end
         ar_prev[c] = init_axi_txn[c];
      end
   endtask

   task automatic wait_rsp(input int ch, input int lim, output int n);
      n = 0;
      while (!rsp_valid[ch] && n < lim) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_init_low(input int ch);
      int g;
      g = 0;
      while (init_axi_txn[ch] && g < 20) begin
         tick();
         g++;
      end
   endtask

   int n, cnt, ng, ovl, noready;
   int gseq [4];

   initial begin
      ARESET = 1; enable = 0; req_valid = '0; txn_done = '0; txn_error = '0;
      for (int c = 0; c < NCH; c++) begin ar_cnt[c] = 0; ar_prev[c] = 0; end
      repeat (3) tick();

      // Single ok transaction on ch0, done edge 10 cycles after init falls
      ARESET = 0; enable = 1; req_valid = 2'b01;
      tick();
      req_valid = '0;
      cnt = 0;
      while (init_axi_txn[0] && cnt < 20) begin cnt++; tick(); end
      check_val("a_init_width", 32'(cnt), 32'd2);
      repeat (10) tick();
      txn_done[0] = 1'b1;
      wait_rsp(0, 5, n);
      check_val("a_rsp_latency", 32'(n), 32'd1);
      check_val("a_status", 32'(rsp_status[1:0]), 32'd0);
      check_val("a_ok_cnt", 32'(ok_cnt), 32'd1);
      txn_done = '0;
      tick();

      // Both requesting: grants alternate starting at ch0
      ARESET = 1; tick(); ARESET = 0;
      auto_en = 1; req_valid = 2'b11; ng = 0; ovl = 0;
      for (int i = 0; i < 300 && ng < 4; i++) begin
         #2;
         if (req_ready[0])      begin gseq[ng] = 0; ng++; end
         else if (req_ready[1]) begin gseq[ng] = 1; ng++; end
         if (init_axi_txn == 2'b11) ovl++;
         tick();
      end
      check_val("b_grants", 32'(ng), 32'd4);
      for (int i = 0; i < 4; i++) check_val("b_order", 32'(gseq[i]), 32'(i % 2));
      check_val("b_init_overlap", 32'(ovl), 32'd0);
      req_valid = '0; auto_en = 0;
      repeat (40) tick();

      // Stale-high done on ch1, then a real edge with error
      ARESET = 1; tick(); ARESET = 0;
      txn_done = 2'b10; txn_error = 2'b10; req_valid = 2'b10;
      tick();
      req_valid = '0;
      wait_init_low(1);
      repeat (5) tick();
      check_val("c_no_early", 32'(busy), 32'd1);
      txn_done[1] = 1'b0;
      tick();
      txn_done[1] = 1'b1;
      wait_rsp(1, 5, n);
      check_val("c_rsp_latency", 32'(n), 32'd1);
      check_val("c_status", 32'(rsp_status[3:2]), 32'd1);
      check_val("c_err_cnt", 32'(err_cnt), 32'd1);
      tick();

      // Timeout: done never rises
      txn_done = '0; txn_error = '0; req_valid = 2'b01;
      tick();
      req_valid = '0;
      wait_init_low(0);
      wait_rsp(0, 40, n);
      check_val("d_timeout_cycles", 32'(n), 32'd16);
      check_val("d_status", 32'(rsp_status[1:0]), 32'd2);
      tick();
      check_val("d_idle", 32'(busy), 32'd0);

      // Done edge on the last timeout cycle; idle-channel edge ignored
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      wait_init_low(0);
      repeat (3) tick();
      txn_done[1] = 1'b1;
      repeat (12) tick();
      txn_done[0] = 1'b1;
      wait_rsp(0, 5, n);
      check_val("e_rsp_latency", 32'(n), 32'd1);
      check_val("e_status", 32'(rsp_status[1:0]), 32'd0);
      txn_done = '0;
      tick();

      // Reset during INIT, then enable low with requests pending
      req_valid = 2'b01;
      tick();
      req_valid = '0; ARESET = 1;
      tick();
      ARESET = 0;
      check_val("f_init", 32'(init_axi_txn), 32'd0);
      check_val("f_busy", 32'(busy), 32'd0);
      check_val("f_cnts", 32'({ok_cnt, err_cnt}), 32'd0);
      enable = 0; req_valid = 2'b11; noready = 0;
      for (int i = 0; i < 10; i++) begin
         #2;
         if (req_ready != '0) noready++;
         tick();
      end
      check_val("f_no_ready", 32'(noready), 32'd0);
      repeat (10) tick();

      // Randomized traffic
      enable = 1; auto_en = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req_valid = 2'($urandom);
         enable = ($urandom_range(0, 9) != 0);
         ARESET = ($urandom_range(0, 799) == 0);
         tick();
      end
      ARESET = 0; req_valid = '0;
      repeat (40) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
